// File: rtl/text_pkg.sv
// Shared definitions for the VGA text-line path: line length, ASCII codes
// used by the text generators and the serial read-back FSM state type.
package text_pkg;

    localparam int TEXT_NCHARS = 8;

    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_LF    = 7'h0A;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: while en is high, emits a one-cycle tick every DIV cycles.
// Dropping en clears the count so each enabled run starts a fresh period.
module uart_baud_gen #(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/text_uart_tx.sv
// Sends a snapshot of the on-screen text line out a UART 8N1 link, leftmost
// character first. Define TEXT_UART_CRLF_EN to append a CR/LF terminator.
module text_uart_tx
    import text_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int NCHARS = TEXT_NCHARS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7*NCHARS-1:0]   chars,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int DIV = CLK_HZ / BAUD;

`ifdef TEXT_UART_CRLF_EN
    localparam int NFRAMES = NCHARS + 2;
`else
    localparam int NFRAMES = NCHARS;
`endif

    localparam int IW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NFRAMES - 1);

    tx_state_t             state;
    logic [7*NCHARS-1:0]   snap;
    logic [IW-1:0]         char_idx;
    logic [2:0]            bit_idx;
    logic [2:0]            next_bit;
    logic [6:0]            cur_char;
    logic [7:0]            cur_byte;
    logic                  tick;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .en    (state != IDLE),
        .tick  (tick)
    );

    // Character for the frame in flight; the two slots past the line are the terminator.
    always_comb begin
        cur_char = ASCII_SPACE;
        for (int i = 0; i < NCHARS; i++) begin
            if (char_idx == IW'(i)) begin
                cur_char = snap[7*i +: 7];
            end
        end
`ifdef TEXT_UART_CRLF_EN
        if (char_idx == IW'(NCHARS)) begin
            cur_char = ASCII_CR;
        end
        if (char_idx == IW'(NCHARS + 1)) begin
            cur_char = ASCII_LF;
        end
`endif
    end

    assign cur_byte = {1'b0, cur_char};
    assign next_bit = bit_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            snap     <= '0;
            char_idx <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap     <= chars;
                        char_idx <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx      <= cur_byte[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end
                end
                STOP: begin
                    // Next start bit follows the stop bit with no idle gap.
                    if (tick) begin
                        if (char_idx == LAST_IDX) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            char_idx <= char_idx + 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
